// File: rtl/hazard_scheduler_if.sv
// Decode-to-hazard-scheduler bundle: decoded operand/dest info in,
// stall and per-operand bypass selects out.
interface hazard_scheduler_if #(
    parameter int XLEN_REGS = 5
);
    logic                 id_valid;
    logic [XLEN_REGS-1:0] id_rs1;
    logic [XLEN_REGS-1:0] id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [XLEN_REGS-1:0] id_rd;
    logic                 id_regWrite;
    logic                 id_memRead;
    logic                 hold;
    logic                 flush;
    logic                 report;
    logic                 stall;
    logic [2:0]           fwd_a_sel;
    logic [2:0]           fwd_b_sel;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_regWrite, id_memRead, hold, flush, report,
        input  stall, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_regWrite, id_memRead, hold, flush, report,
        output stall, fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: shadow scoreboard of EX/MI/MR/WB,
// stall and bypass selection. Optional stats via HAZARD_STATS_EN.
module hazard_scheduler #(
    parameter int CORE      = 0,
    parameter int XLEN_REGS = 5
) (
    input logic               clock,
    input logic               reset,
    hazard_scheduler_if.slave bus
);
    typedef logic [XLEN_REGS-1:0] reg_t;

    typedef struct packed {
        logic valid;
        reg_t rd;
        logic reg_write;
        logic mem_read;
    } sb_entry_t;

    // index 0 = EX, 1 = MI, 2 = MR, 3 = WB
    sb_entry_t [3:0] sb;
    sb_entry_t       d;
    logic [3:0]      res_a;
    logic [3:0]      res_b;
    logic            stall_c;

    // {hazard, sel}: walk oldest to youngest so the youngest match wins
    function automatic logic [3:0] resolve(
        input sb_entry_t [3:0] e,
        input reg_t            rs,
        input logic            used
    );
        logic [3:0] r;
        r = '0;
        if (used && rs != '0) begin
            for (int i = 3; i >= 0; i--) begin
                if (e[i].valid && e[i].reg_write && e[i].rd == rs) begin
                    if (e[i].mem_read && i != 3)
                        r = 4'b1000;
                    else
                        r = {1'b0, 3'(i + 1)};
                end
            end
        end
        return r;
    endfunction

    // hazard detection and bypass selection for the instruction in decode
    always_comb begin
        res_a = resolve(sb, bus.id_rs1, bus.id_valid & bus.id_rs1_used);
        res_b = resolve(sb, bus.id_rs2, bus.id_valid & bus.id_rs2_used);
        stall_c = (res_a[3] | res_b[3]) & ~bus.flush;
        bus.stall = stall_c;
        bus.fwd_a_sel = stall_c ? 3'd0 : res_a[2:0];
        bus.fwd_b_sel = stall_c ? 3'd0 : res_b[2:0];
    end

    // entry entering EX: a bubble when stalled or flushed
    always_comb begin
        d.valid = bus.id_valid & ~stall_c & ~bus.flush;
        d.rd = bus.id_rd;
        d.reg_write = bus.id_regWrite;
        d.mem_read = bus.id_memRead;
    end

    // scoreboard shift; frozen while hold is high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb <= '0;
        end else if (!bus.hold) begin
            sb[3] <= sb[2];
            sb[2] <= sb[1];
            sb[1] <= sb[0];
            sb[0] <= d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] cycles;
    logic [31:0] stall_cycles;
    logic [31:0] load_use_events;
    logic [31:0] bypass_count;
    logic        stall_q;

    // performance counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
            stall_cycles <= '0;
            load_use_events <= '0;
            bypass_count <= '0;
            stall_q <= 1'b0;
        end else begin
            cycles <= cycles + 32'd1;
            if (stall_c && !bus.hold)
                stall_cycles <= stall_cycles + 32'd1;
            if (stall_c && !stall_q)
                load_use_events <= load_use_events + 32'd1;
            stall_q <= stall_c;
            bypass_count <= bypass_count
                + 32'(bus.fwd_a_sel != 3'd0)
                + 32'(bus.fwd_b_sel != 3'd0);
        end
    end

    // stats dump while report is asserted
    always_ff @(posedge clock) begin
        if (reset && bus.report)
            $display("core %0d cycles=%0d stall_cycles=%0d load_use=%0d bypass=%0d",
                     CORE, cycles, stall_cycles, load_use_events, bypass_count);
    end
`else
    logic unused_report;
    assign unused_report = bus.report;
`endif
endmodule
